// File: rtl/pt_rf_pkg.sv
// rtl/pt_rf_pkg.sv - shared types and constants for the register-file arbiter
package pt_rf_pkg;

    localparam int unsigned PT_RF_ADDR_W = 32;
    localparam int unsigned PT_RF_DATA_W = 64;

    // A response comes back exactly this many cycles after the enable.
    localparam int unsigned rf_resp_latency = 1;

    typedef struct packed {
        logic [PT_RF_ADDR_W-1:0] address;
        logic [PT_RF_DATA_W-1:0] wr_data;
        logic                    write;
        logic                    lock;
    } rf_req_t;

    typedef struct packed {
        logic                    write;
        logic [PT_RF_DATA_W-1:0] data;
        logic                    error;
    } rf_rsp_t;

endpackage

// File: rtl/pt_rr_arbiter.sv
// rtl/pt_rr_arbiter.sv - combinational round-robin picker over a masked request vector
module pt_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] elig;
    logic         found;
    int           j;

    assign elig = req & mask;

    // Search upward from ptr with wrap-around; first eligible requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && elig[j]) begin
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pt_rf_arbiter.sv
// rtl/pt_rf_arbiter.sv - round-robin sharing of one register-file port with lock and response routing
module pt_rf_arbiter
    import pt_rf_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int RF_ADDR_W    = PT_RF_ADDR_W,
    parameter int DATA_W       = PT_RF_DATA_W,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [N_REQ-1:0]                   i_req_valid,
    output logic [N_REQ-1:0]                   o_req_ready,
    input  logic [N_REQ-1:0][RF_ADDR_W-1:0]    i_req_address,
    input  logic [N_REQ-1:0][DATA_W-1:0]       i_req_wr_data,
    input  logic [N_REQ-1:0]                   i_req_write,
    input  logic [N_REQ-1:0]                   i_req_lock,
    output logic [N_REQ-1:0]                   o_rsp_valid,
    output logic [DATA_W-1:0]                  o_rsp_rd_data,
    output logic                               o_rsp_error,
    output logic                               o_rsp_write,
    output logic [RF_ADDR_W-1:0]               o_rf_address,
    output logic [DATA_W-1:0]                  o_rf_wr_data,
    output logic                               o_rf_write,
    output logic                               o_rf_enable,
    input  logic [DATA_W-1:0]                  i_rf_rd_data,
    input  logic                               i_rf_error,
    output logic                               o_locked
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [IDX_W-1:0]           rr_ptr_q;
    logic                       lock_q;
    logic [IDX_W-1:0]           lock_owner_q;
    logic [CNT_W-1:0]           lock_cnt_q;
    logic [rf_resp_latency-1:0] pend_valid_q;
    logic [IDX_W-1:0]           pend_idx_q;
    logic                       pend_write_q;

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] win_idx;
    logic             any_grant;

    always_comb begin
        mask = '1;
        if (lock_q) begin
            mask               = '0;
            mask[lock_owner_q] = 1'b1;
        end
    end

    pt_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (i_req_valid),
        .ptr   (rr_ptr_q),
        .mask  (mask),
        .grant (grant),
        .idx   (win_idx)
    );

    assign any_grant   = |grant;
    assign o_req_ready = grant;
    assign o_rf_enable = any_grant;
    assign o_locked    = lock_q;

    always_comb begin
        o_rf_address = '0;
        o_rf_wr_data = '0;
        o_rf_write   = 1'b0;
        if (any_grant) begin
            o_rf_address = i_req_address[win_idx];
            o_rf_wr_data = i_req_wr_data[win_idx];
            o_rf_write   = i_req_write[win_idx];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            pend_valid_q <= '0;
            pend_idx_q   <= '0;
            pend_write_q <= 1'b0;
        end else begin
            pend_valid_q <= rf_resp_latency'(any_grant);
            if (any_grant) begin
                rr_ptr_q     <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                pend_idx_q   <= win_idx;
                pend_write_q <= i_req_write[win_idx];
                lock_cnt_q   <= '0;
                if (i_req_lock[win_idx]) begin
                    lock_q       <= 1'b1;
                    lock_owner_q <= win_idx;
                end else begin
                    // While locked only the owner can win, so this is the owner releasing.
                    lock_q <= 1'b0;
                end
            end else if (lock_q && !i_req_valid[lock_owner_q]) begin
                if (lock_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    lock_q     <= 1'b0;
                    lock_cnt_q <= '0;
                end else begin
                    lock_cnt_q <= lock_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_rsp_valid = '0;
        if (pend_valid_q[0]) o_rsp_valid[pend_idx_q] = 1'b1;
    end

    assign o_rsp_rd_data = i_rf_rd_data;
    assign o_rsp_error   = i_rf_error;
    assign o_rsp_write   = pend_write_q;

endmodule

// File: tb/tb_pt_rf_arbiter.sv
// tb/tb_pt_rf_arbiter.sv - directed self-checking bench for pt_rf_arbiter (3 requesters, lock timeout 4)
module tb_pt_rf_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic [N-1:0]            i_req_valid;
    logic [N-1:0]            o_req_ready;
    logic [N-1:0][AW-1:0]    i_req_address;
    logic [N-1:0][DW-1:0]    i_req_wr_data;
    logic [N-1:0]            i_req_write;
    logic [N-1:0]            i_req_lock;
    logic [N-1:0]            o_rsp_valid;
    logic [DW-1:0]           o_rsp_rd_data;
    logic                    o_rsp_error;
    logic                    o_rsp_write;
    logic [AW-1:0]           o_rf_address;
    logic [DW-1:0]           o_rf_wr_data;
    logic                    o_rf_write;
    logic                    o_rf_enable;
    logic [DW-1:0]           i_rf_rd_data;
    logic                    i_rf_error;
    logic                    o_locked;

    int n_cmp = 0;
    int n_err = 0;

    pt_rf_arbiter #(
        .N_REQ        (N),
        .RF_ADDR_W    (AW),
        .DATA_W       (DW),
        .LOCK_TIMEOUT (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_address (i_req_address),
        .i_req_wr_data (i_req_wr_data),
        .i_req_write   (i_req_write),
        .i_req_lock    (i_req_lock),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_rd_data (o_rsp_rd_data),
        .o_rsp_error   (o_rsp_error),
        .o_rsp_write   (o_rsp_write),
        .o_rf_address  (o_rf_address),
        .o_rf_wr_data  (o_rf_wr_data),
        .o_rf_write    (o_rf_write),
        .o_rf_enable   (o_rf_enable),
        .i_rf_rd_data  (i_rf_rd_data),
        .i_rf_error    (i_rf_error),
        .o_locked      (o_locked)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_valid  = '0;
        i_req_write  = '0;
        i_req_lock   = '0;
        i_rf_rd_data = '0;
        i_rf_error   = 1'b0;
        for (int i = 0; i < N; i++) begin
            i_req_address[i] = AW'(32'h100 + i * 4);
            i_req_wr_data[i] = DW'(64'hA000 + i);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_inputs();
        step();
        step();
        i_rst = 1'b0;
        #1;
        n_cmp++; if (o_req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got=%b exp=000", o_req_ready); end
        n_cmp++; if (o_rf_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable got=%b exp=0", o_rf_enable); end
        n_cmp++; if (o_rf_write !== 1'b0) begin n_err++; $display("FAIL reset_write got=%b exp=0", o_rf_write); end
        n_cmp++; if (o_rsp_valid !== 3'b000) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=000", o_rsp_valid); end
        n_cmp++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got=%b exp=0", o_locked); end
        step();
    endtask

    // Pointer starts at 0: grants 0,1,2,0,1,2 with each response one cycle later.
    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_r;
        i_req_valid = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            exp_r = (k == 0) ? 3'b000 : 3'b001 << ((k - 1) % 3);
            n_cmp++; if (o_req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, o_req_ready, exp_g); end
            n_cmp++; if (o_rf_address !== AW'(32'h100 + (k % 3) * 4)) begin n_err++; $display("FAIL rr_addr[%0d] got=%h exp=%h", k, o_rf_address, 32'h100 + (k % 3) * 4); end
            n_cmp++; if (o_rsp_valid !== exp_r) begin n_err++; $display("FAIL rr_rsp[%0d] got=%b exp=%b", k, o_rsp_valid, exp_r); end
            step();
        end
        i_req_valid = 3'b000;
        #1;
        n_cmp++; if (o_rsp_valid !== 3'b100) begin n_err++; $display("FAIL rr_last_rsp got=%b exp=100", o_rsp_valid); end
        n_cmp++; if (o_rf_enable !== 1'b0) begin n_err++; $display("FAIL rr_idle_enable got=%b exp=0", o_rf_enable); end
        step();
    endtask

    // Pointer is 0 here.
    task automatic test_read();
        i_req_valid      = 3'b001;
        i_req_address[0] = 32'h10;
        #1;
        n_cmp++; if (o_req_ready !== 3'b001) begin n_err++; $display("FAIL rd_ready got=%b exp=001", o_req_ready); end
        n_cmp++; if (o_rf_address !== 32'h10 || o_rf_write !== 1'b0 || o_rf_enable !== 1'b1) begin n_err++; $display("FAIL rd_req got=%h/%b/%b exp=10/0/1", o_rf_address, o_rf_write, o_rf_enable); end
        step();
        i_req_valid  = 3'b000;
        i_rf_rd_data = 64'hDEAD;
        #1;
        n_cmp++; if (o_rsp_valid !== 3'b001) begin n_err++; $display("FAIL rd_rsp_valid got=%b exp=001", o_rsp_valid); end
        n_cmp++; if (o_rsp_rd_data !== 64'hDEAD) begin n_err++; $display("FAIL rd_data got=%h exp=dead", o_rsp_rd_data); end
        n_cmp++; if (o_rsp_write !== 1'b0) begin n_err++; $display("FAIL rd_rsp_write got=%b exp=0", o_rsp_write); end
        step();
        idle_inputs();
    endtask

    // Pointer is 1: req1 locks with a read, then writes 0x10 and releases.
    task automatic test_lock_release();
        i_req_valid = 3'b111;
        i_req_lock  = 3'b010;
        #1;
        n_cmp++; if (o_req_ready !== 3'b010 || o_locked !== 1'b0) begin n_err++; $display("FAIL lk_first got=%b/%b exp=010/0", o_req_ready, o_locked); end
        step();
        i_req_lock       = 3'b000;
        i_req_write      = 3'b010;
        i_req_address[1] = 32'h10;
        #1;
        n_cmp++; if (o_req_ready !== 3'b010 || o_locked !== 1'b1) begin n_err++; $display("FAIL lk_second got=%b/%b exp=010/1", o_req_ready, o_locked); end
        n_cmp++; if (o_rf_write !== 1'b1 || o_rf_address !== 32'h10) begin n_err++; $display("FAIL lk_wr_req got=%b/%h exp=1/10", o_rf_write, o_rf_address); end
        n_cmp++; if (o_rsp_valid !== 3'b010) begin n_err++; $display("FAIL lk_rsp got=%b exp=010", o_rsp_valid); end
        step();
        i_req_valid = 3'b101;
        i_req_write = 3'b000;
        #1;
        n_cmp++; if (o_req_ready !== 3'b100 || o_locked !== 1'b0) begin n_err++; $display("FAIL lk_after got=%b/%b exp=100/0", o_req_ready, o_locked); end
        n_cmp++; if (o_rsp_write !== 1'b1) begin n_err++; $display("FAIL lk_rsp_write got=%b exp=1", o_rsp_write); end
        step();
        #1;
        n_cmp++; if (o_req_ready !== 3'b001) begin n_err++; $display("FAIL lk_then0 got=%b exp=001", o_req_ready); end
        step();
        idle_inputs();
        step();
    endtask

    // Pointer is 1: req2 locks then idles; req0 waits out four idle cycles.
    task automatic test_lock_timeout();
        i_req_valid = 3'b100;
        i_req_lock  = 3'b100;
        #1;
        n_cmp++; if (o_req_ready !== 3'b100) begin n_err++; $display("FAIL to_grant got=%b exp=100", o_req_ready); end
        step();
        i_req_valid = 3'b001;
        i_req_lock  = 3'b000;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (o_req_ready !== 3'b000 || o_locked !== 1'b1) begin n_err++; $display("FAIL to_hold[%0d] got=%b/%b exp=000/1", c, o_req_ready, o_locked); end
            step();
        end
        #1;
        n_cmp++; if (o_req_ready !== 3'b001 || o_locked !== 1'b0) begin n_err++; $display("FAIL to_release got=%b/%b exp=001/0", o_req_ready, o_locked); end
        step();
        idle_inputs();
        step();
    endtask

    // Pointer is 1.
    task automatic test_write_error();
        i_req_valid = 3'b010;
        i_req_write = 3'b010;
        #1;
        n_cmp++; if (o_req_ready !== 3'b010 || o_rf_write !== 1'b1) begin n_err++; $display("FAIL we_req got=%b/%b exp=010/1", o_req_ready, o_rf_write); end
        n_cmp++; if (o_rf_wr_data !== 64'hA001) begin n_err++; $display("FAIL we_wdata got=%h exp=a001", o_rf_wr_data); end
        step();
        i_req_valid = 3'b000;
        i_req_write = 3'b000;
        i_rf_error  = 1'b1;
        #1;
        n_cmp++; if (o_rsp_valid !== 3'b010) begin n_err++; $display("FAIL we_rsp_valid got=%b exp=010", o_rsp_valid); end
        n_cmp++; if (o_rsp_error !== 1'b1 || o_rsp_write !== 1'b1) begin n_err++; $display("FAIL we_err got=%b/%b exp=1/1", o_rsp_error, o_rsp_write); end
        step();
        idle_inputs();
    endtask

    // Pointer is 2: req2 takes the lock, reset hits with its response pending.
    task automatic test_reset_mid();
        i_req_valid = 3'b100;
        i_req_lock  = 3'b100;
        #1;
        n_cmp++; if (o_req_ready !== 3'b100) begin n_err++; $display("FAIL rm_grant got=%b exp=100", o_req_ready); end
        step();
        idle_inputs();
        #1;
        n_cmp++; if (o_rsp_valid !== 3'b100 || o_locked !== 1'b1) begin n_err++; $display("FAIL rm_pre got=%b/%b exp=100/1", o_rsp_valid, o_locked); end
        i_rst = 1'b1;
        #1;
        n_cmp++; if (o_rsp_valid !== 3'b000 || o_locked !== 1'b0) begin n_err++; $display("FAIL rm_during got=%b/%b exp=000/0", o_rsp_valid, o_locked); end
        step();
        i_rst       = 1'b0;
        i_req_valid = 3'b111;
        #1;
        n_cmp++; if (o_req_ready !== 3'b001) begin n_err++; $display("FAIL rm_first got=%b exp=001", o_req_ready); end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read();
        test_lock_release();
        test_lock_timeout();
        test_write_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
